// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch display path: digit count, slot
// numbering, active-high 7-segment patterns (bit order g,f,e,d,c,b,a)
// and the decimal-point slot mask.
package stopwatch_pkg;

   localparam int NUM_DIGITS = 6;

   // Slot numbering, rightmost digit first
   localparam logic [2:0] SLOT_10MS  = 3'd0;
   localparam logic [2:0] SLOT_100MS = 3'd1;
   localparam logic [2:0] SLOT_1SEC  = 3'd2;
   localparam logic [2:0] SLOT_10SEC = 3'd3;
   localparam logic [2:0] SLOT_1MIN  = 3'd4;
   localparam logic [2:0] SLOT_10MIN = 3'd5;

   // Active-high segment patterns, {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0    = 7'b0111111;
   localparam logic [6:0] SEG_1    = 7'b0000110;
   localparam logic [6:0] SEG_2    = 7'b1011011;
   localparam logic [6:0] SEG_3    = 7'b1001111;
   localparam logic [6:0] SEG_4    = 7'b1100110;
   localparam logic [6:0] SEG_5    = 7'b1101101;
   localparam logic [6:0] SEG_6    = 7'b1111101;
   localparam logic [6:0] SEG_7    = 7'b0000111;
   localparam logic [6:0] SEG_8    = 7'b1111111;
   localparam logic [6:0] SEG_9    = 7'b1101111;
   localparam logic [6:0] SEG_DASH = 7'b1000000;
   localparam logic [6:0] SEG_OFF  = 7'b0000000;

   // Decimal point after minutes (slot 4) and seconds (slot 2): "MM.SS.cc"
   localparam logic [NUM_DIGITS-1:0] DP_SLOT_MASK = 6'b010100;

   // One-hot slot select; unreachable slot codes 6/7 select nothing
   function automatic logic [NUM_DIGITS-1:0] slot_onehot(input logic [2:0] slot);
      logic [NUM_DIGITS-1:0] oh;
      oh = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (slot == 3'(i)) oh[i] = 1'b1;
      end
      return oh;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD to 7-segment decoder, purely combinational, active-high output.
// Codes 10..15 are not valid BCD and show a dash so a corrupted digit is
// visible on the display instead of a misleading numeral.
module seg7_decode
   import stopwatch_pkg::*;
(
   input  logic [3:0] bcd_i,
   output logic [6:0] seg_o
);

   // Pattern lookup
   always_comb begin
      seg_o = SEG_DASH;
      case (bcd_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/stopwatch_display.sv
// Six-digit multiplexed 7-segment driver for the stopwatch BCD digits.
// The digits are captured into a snapshot at each frame boundary (unless
// hold is set), so one scan frame never mixes old and new time values.
// seg/dp/an are registered: they follow the slot index with one cycle of
// latency and are glitch-free at the pins.
// Optional build macro STOPWATCH_DISPLAY_LZB_EN enables leading-zero
// blanking of the 10min, 1min and 10sec digits.
// reset_n asserts asynchronously; its release is expected to come from a
// source already synchronous to clk.
module stopwatch_display
   import stopwatch_pkg::*;
#(
   parameter int TICK_DIV       = 100000,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       enable,
   input  logic       hold,
   input  logic [3:0] timer10ms,
   input  logic [3:0] timer100ms,
   input  logic [3:0] timer1sec,
   input  logic [3:0] timer10sec,
   input  logic [3:0] timer1min,
   input  logic [3:0] timer10min,
   output logic [6:0] seg,
   output logic       dp,
   output logic [5:0] an,
   output logic       frame_done
);

   localparam int              PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0]   TICK_LAST = PW'(TICK_DIV - 1);

   // XOR masks that turn internal active-high values into pin polarity
   localparam logic [6:0]            SEG_POL = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic                  DP_POL  = SEG_ACTIVE_LOW;
   localparam logic [NUM_DIGITS-1:0] AN_POL  = SEG_ACTIVE_LOW ? 6'h3F : 6'h00;

   logic [PW-1:0]                 pre_q, pre_d;
   logic [2:0]                    idx_q, idx_d;
   logic [NUM_DIGITS-1:0][3:0]    snap_q, snap_d;
   logic [6:0]                    seg_q, seg_d;
   logic                          dp_q, dp_d;
   logic [NUM_DIGITS-1:0]         an_q, an_d;

   logic                          tick;
   logic                          frame;
   logic [3:0]                    digit;
   logic [6:0]                    dec_seg;
   logic                          blank;
   logic [NUM_DIGITS-1:0]         slot_oh;

   // Prescaler, slot index and snapshot next-state
   always_comb begin
      tick   = (pre_q == TICK_LAST);
      frame  = tick && (idx_q == SLOT_10MIN);
      pre_d  = tick ? '0 : pre_q + 1'b1;
      idx_d  = idx_q;
      if (tick) begin
         // 5 wraps to 0; the unreachable codes 6 and 7 recover the same way
         idx_d = (idx_q >= SLOT_10MIN) ? SLOT_10MS : idx_q + 3'd1;
      end
      snap_d = snap_q;
      if (frame && !hold) begin
         snap_d = {timer10min, timer1min, timer10sec, timer1sec, timer100ms, timer10ms};
      end
   end

   // Counter and snapshot registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pre_q  <= '0;
         idx_q  <= SLOT_10MS;
         snap_q <= '0;
      end else begin
         pre_q  <= pre_d;
         idx_q  <= idx_d;
         snap_q <= snap_d;
      end
   end

   // Select the snapshot digit for the current slot
   always_comb begin
      digit = 4'd0;
      case (idx_q)
         SLOT_10MS:  digit = snap_q[0];
         SLOT_100MS: digit = snap_q[1];
         SLOT_1SEC:  digit = snap_q[2];
         SLOT_10SEC: digit = snap_q[3];
         SLOT_1MIN:  digit = snap_q[4];
         SLOT_10MIN: digit = snap_q[5];
         default:    digit = 4'd0;
      endcase
   end

   seg7_decode u_decode (
      .bcd_i (digit),
      .seg_o (dec_seg)
   );

   // Leading-zero blanking: a leading digit blanks only if every digit to its left is zero
   always_comb begin
      blank = 1'b0;
`ifdef STOPWATCH_DISPLAY_LZB_EN
      case (idx_q)
         SLOT_10MIN: blank = (snap_q[5] == 4'd0);
         SLOT_1MIN:  blank = (snap_q[5] == 4'd0) && (snap_q[4] == 4'd0);
         SLOT_10SEC: blank = (snap_q[5] == 4'd0) && (snap_q[4] == 4'd0) && (snap_q[3] == 4'd0);
         default:    blank = 1'b0;
      endcase
`endif
   end

   // Active-high output values, then polarity applied just before the register
   always_comb begin
      slot_oh = slot_onehot(idx_q);
      an_d    = AN_POL;
      seg_d   = SEG_POL;
      dp_d    = DP_POL;
      if (enable) begin
         an_d  = slot_oh ^ AN_POL;
         seg_d = (blank ? SEG_OFF : dec_seg) ^ SEG_POL;
         dp_d  = (|(slot_oh & DP_SLOT_MASK)) ^ DP_POL;
      end
   end

   // Output register, reset to all-inactive
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         an_q  <= AN_POL;
         seg_q <= SEG_POL;
         dp_q  <= DP_POL;
      end else begin
         an_q  <= an_d;
         seg_q <= seg_d;
         dp_q  <= dp_d;
      end
   end

   assign seg        = seg_q;
   assign dp         = dp_q;
   assign an         = an_q;
   assign frame_done = frame;

endmodule

// File: tb/tb_stopwatch_display.sv
// Scoreboard bench for stopwatch_display (TICK_DIV=4, active-low pins).
// A reference model predicts frame_done for the current cycle and the
// registered {an,seg,dp} for the next edge; predictions are queued and
// compared once the DUT has produced them.
module tb_stopwatch_display;

   localparam int TD = 4;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       enable = 1'b1;
   logic       hold = 1'b0;
   logic [3:0] timer10ms = 4'd0, timer100ms = 4'd0, timer1sec = 4'd0;
   logic [3:0] timer10sec = 4'd0, timer1min = 4'd0, timer10min = 4'd0;
   logic [6:0] seg;
   logic       dp;
   logic [5:0] an;
   logic       frame_done;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   int         m_cnt;
   int         m_idx;
   logic [3:0] m_snap [6];
   logic [13:0] sb [$];

   int cyc;
   int first_fd;
   int fd_cnt;

   stopwatch_display #(.TICK_DIV(TD), .SEG_ACTIVE_LOW(1'b1)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .enable     (enable),
      .hold       (hold),
      .timer10ms  (timer10ms),
      .timer100ms (timer100ms),
      .timer1sec  (timer1sec),
      .timer10sec (timer10sec),
      .timer1min  (timer1min),
      .timer10min (timer10min),
      .seg        (seg),
      .dp         (dp),
      .an         (an),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h at %0t", tag, got, want, $time);
      end
   endtask

   function automatic logic [6:0] ref_seg(input logic [3:0] d);
      case (d)
         4'd0: return 7'b0111111;
         4'd1: return 7'b0000110;
         4'd2: return 7'b1011011;
         4'd3: return 7'b1001111;
         4'd4: return 7'b1100110;
         4'd5: return 7'b1101101;
         4'd6: return 7'b1111101;
         4'd7: return 7'b0000111;
         4'd8: return 7'b1111111;
         4'd9: return 7'b1101111;
         default: return 7'b1000000;
      endcase
   endfunction

   // expected pin values {an,seg,dp}, active-low
   function automatic logic [13:0] ref_out(input int idx, input logic en);
      logic [5:0] a;
      logic [6:0] s;
      logic       d;
      logic       blk;
      a = 6'd0; s = 7'd0; d = 1'b0; blk = 1'b0;
`ifdef STOPWATCH_DISPLAY_LZB_EN
      if (idx == 5) blk = (m_snap[5] == 0);
      if (idx == 4) blk = (m_snap[5] == 0) && (m_snap[4] == 0);
      if (idx == 3) blk = (m_snap[5] == 0) && (m_snap[4] == 0) && (m_snap[3] == 0);
`endif
      if (en) begin
         a[idx] = 1'b1;
         s = blk ? 7'd0 : ref_seg(m_snap[idx]);
         d = (idx == 2) || (idx == 4);
      end
      return ~{a, s, d};
   endfunction

   task automatic model_reset();
      m_cnt = 0;
      m_idx = 0;
      for (int i = 0; i < 6; i++) m_snap[i] = 4'd0;
      sb.delete();
      cyc = 0;
   endtask

   task automatic set_digits(input logic [3:0] d5, d4, d3, d2, d1, d0);
      timer10min = d5; timer1min = d4; timer10sec = d3;
      timer1sec  = d2; timer100ms = d1; timer10ms = d0;
   endtask

   // one clock: check frame_done, queue prediction, advance, compare outputs
   task automatic step();
      logic tick, fd_exp;
      logic [13:0] want;
      @(negedge clk);
      cyc++;
      tick   = (m_cnt == TD - 1);
      fd_exp = tick && (m_idx == 5);
      if (frame_done === 1'b1) begin
         fd_cnt++;
         if (first_fd == 0) first_fd = cyc;
      end
      check("frame_done", {31'd0, frame_done}, {31'd0, fd_exp});
      sb.push_back(ref_out(m_idx, enable));
      @(posedge clk);
      if (fd_exp && !hold) begin
         m_snap[0] = timer10ms;  m_snap[1] = timer100ms; m_snap[2] = timer1sec;
         m_snap[3] = timer10sec; m_snap[4] = timer1min;  m_snap[5] = timer10min;
      end
      if (tick) m_idx = (m_idx == 5) ? 0 : m_idx + 1;
      m_cnt = tick ? 0 : m_cnt + 1;
      #1;
      want = sb.pop_front();
      check("an_seg_dp", {18'd0, an, seg, dp}, {18'd0, want});
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      bit found;
      model_reset();
      first_fd = 0;
      fd_cnt   = 0;
      set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_an", {26'd0, an}, 32'h3F);
      check("rst_seg", {25'd0, seg}, 32'h7F);
      check("rst_dp", {31'd0, dp}, 32'd1);
      check("rst_frame_done", {31'd0, frame_done}, 32'd0);

      // release and scan: frame 1 zeros, frame 2 shows 6,5,4,3,2,1
      reset_n = 1'b1;
      run(24);
      check("first_frame_cycle", first_fd, 24);
      run(24);

      // coherency: change inputs at slot 3 of a frame
      run(12);
      set_digits(4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9);
      run(12 + 24);

      // hold for 3 frames while inputs change, then release
      hold = 1'b1;
      run(4);
      set_digits(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd7);
      run(20 + 48);
      hold = 1'b0;
      run(48);

      // invalid BCD shows a dash on slot 2
      timer1sec = 4'hC;
      run(24);
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         step();
         if (an == 6'b111011) found = 1'b1;
      end
      check("dash_slot_seen", {31'd0, found}, 32'd1);
      check("dash_seg", {25'd0, seg}, 32'h3F);

      // enable=0 blanks one cycle later; frame_done continues
      enable = 1'b0;
      step();
      check("dis_an", {26'd0, an}, 32'h3F);
      check("dis_seg", {25'd0, seg}, 32'h7F);
      fd_cnt = 0;
      run(24);
      check("dis_frame_done_count", fd_cnt, 1);
      enable = 1'b1;
      run(24);

      // async reset mid-frame, at slot 4
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         step();
         if (an == 6'b101111) found = 1'b1;
      end
      check("slot4_seen", {31'd0, found}, 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_an", {26'd0, an}, 32'h3F);
      check("arst_seg", {25'd0, seg}, 32'h7F);
      check("arst_dp", {31'd0, dp}, 32'd1);
      check("arst_frame_done", {31'd0, frame_done}, 32'd0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      run(48);

      // leading-zero pattern 0,0,0,5,1,2
      set_digits(4'd0, 4'd0, 4'd0, 4'd5, 4'd1, 4'd2);
      run(48);

      check("sb_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
